ram_arbiter: RTL
================

# ram_arbiter

Two-port arbiter and access sequencer for the shared 4-bit data RAM. The CPU control path (requester 0) and the program loader/debug port (requester 1) share the RAM and its tri-state data bus. The block grants the bus, registers address, data and direction, and sequences chip-select, write-enable and bus-drive so the RAM's level-sensitive write never sees a changing address or a bus conflict. It sits between the decode/control logic and the `RAM` + `Triestate` pair.

## Interface
Parameters:
- `FIXED_PRIORITY`, 0: 0 = round-robin between requesters; 1 = requester 0 always wins ties.
- `WAIT_STATES`, 0: extra ACCESS cycles, range 0..7. The counter is 3 bits wide.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  level request; held high until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled only at grant.
- `addr0`, `addr1`  in  12  RAM address; sampled only at grant.
- `wdata0`, `wdata1`  in  4  write data; sampled only at grant.
- `ack0`, `ack1`  out  1  one-cycle completion pulse, registered.
- `rdata`  out  4  read data, shared by both requesters; valid while the matching ack is high.
- `busy`  out  1  high whenever the state is not IDLE.
- `ram_addr`  out  12  registered RAM address.
- `ram_cs`  out  1  RAM chip select.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  4  data to the `Triestate` input.
- `ram_drive`  out  1  `Triestate` enable.
- `ram_rdata`  in  4  RAM data bus as seen by the block.

## Operation
- States: IDLE, ACCESS, TURN.
- Reset (synchronous) forces, on the next edge:
  - state IDLE
  - all outputs 0: `ack*`, `rdata`, `busy`, `ram_addr`, `ram_cs`, `ram_we`, `ram_wdata`, `ram_drive`
  - wait counter 0
  - `last_grant` = 1, so requester 0 wins the first tie.
- IDLE:
  - If neither request is high, stay in IDLE.
  - One request high: grant it.
  - Both high with `FIXED_PRIORITY`=0: grant the requester opposite `last_grant`.
  - Both high with `FIXED_PRIORITY`=1: grant requester 0.
  - On grant: latch the winner's `addr`/`we`/`wdata` into `ram_addr`/`ram_we`/`ram_wdata`; record the winner in the `grant` register and in `last_grant`; load the wait counter with `WAIT_STATES`; go to ACCESS.
- ACCESS:
  - `ram_cs`=1. `ram_we` and `ram_drive` equal the latched `we`.
  - `ram_addr` and `ram_wdata` stay constant for the whole state.
  - While the counter is nonzero, decrement it and stay.
  - When the counter is 0: capture `ram_rdata` into `rdata` on reads (`rdata` is unchanged on writes); drive the granted ack high; go to TURN.
- TURN, one cycle:
  - `ram_cs`, `ram_we` and `ram_drive` are 0. `ram_addr` is held. Ack is high.
  - Go to IDLE.
  - Gives the bus a turnaround cycle and keeps the address stable while `we` falls.
- Requester rule: clear `req` on the edge that samples ack high. A req still high in the following IDLE cycle is a new transaction.
- A req dropped after grant does not abort the access: it completes and the ack still pulses.
- The losing requester keeps its req high and is served next. Round-robin guarantees service within one transaction.
- `ram_drive` and `ram_cs & ~ram_we` are never both 1.

## Timing
- All outputs are registered. Nothing is combinational from inputs to outputs.
- Req high at IDLE edge E0: ACCESS during cycles E0+1 .. E0+1+W; ack during cycle E0+2+W, where W = `WAIT_STATES`.
- Request-to-ack latency is 2+W cycles. Back-to-back throughput is one access per 3+W cycles.
- `rdata` holds its value until the next read completes.
- Reset asserted mid-ACCESS: `ram_cs`, `ram_we` and `ram_drive` are 0 from the next edge. No ack is issued and the pending request is lost.
- Requests are ignored while `busy`=1.
- `ram_addr` changes only on the edge leaving IDLE.

## Test plan
- Reset, then `req0`=1, `we0`=1, `addr0`=0x123, `wdata0`=0xA with W=0 -> `ram_cs`=1, `ram_we`=1, `ram_drive`=1 for exactly 1 cycle; `ack0` pulses 2 cycles after the request edge; address is 0x123 throughout.
- Read back 0x123 via `req1` -> `ram_cs`=1, `ram_we`=0, `ram_drive`=0; `ack1` high with `rdata`=0xA; `ack0` stays 0.
- Both requesters held high for 4 transactions with `FIXED_PRIORITY`=0 -> grant order 0,1,0,1. With `FIXED_PRIORITY`=1 and `req0` always high -> `req1` is never granted.
- `WAIT_STATES`=3, one read -> `ram_cs` high for exactly 4 cycles; ack at request edge +5.
- Reset asserted in the 2nd ACCESS cycle with W=3 -> next cycle `ram_cs`=`ram_we`=`ram_drive`=0, `busy`=0, no ack; a following `req0` is granted normally.
- `req0` dropped one cycle after grant -> the access still completes and `ack0` pulses once. Check every cycle that `ram_drive` and `ram_cs & ~ram_we` are never both 1.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshakes plus the registered RAM/Triestate side of the shared data RAM.
interface ram_arbiter_if;
  logic        req0, req1, we0, we1;
  logic [11:0] addr0, addr1;
  logic [3:0]  wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [3:0]  rdata;
  logic [11:0] ram_addr;
  logic        ram_cs, ram_we, ram_drive;
  logic [3:0]  ram_wdata, ram_rdata;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    output ack0, ack1, rdata, busy, ram_addr, ram_cs, ram_we, ram_wdata, ram_drive
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
    input  ack0, ack1, rdata, busy, ram_addr, ram_cs, ram_we, ram_wdata, ram_drive
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: grants the shared 4-bit RAM to one of two requesters and sequences cs/we/drive
// so the level-sensitive write always sees a stable address and no bus conflict.
module ram_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int WAIT_STATES    = 0
) (
  input  logic      clk,
  input  logic      reset,
  ram_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, TURN = 2'd2;
  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic        r_grant, r_last_grant;
  logic        r_ack0, r_ack1, r_busy, r_cs, r_we, r_drive;
  logic [3:0]  r_rdata, r_wdata;
  logic [11:0] r_addr;
  logic        w_any, w_pick1;
  assign w_any   = bus.req0 | bus.req1;
  // requester 1 wins alone, or on a tie when round-robin and requester 0 went last
  assign w_pick1 = bus.req1 & (~bus.req0 | ((FIXED_PRIORITY == 0) & ~r_last_grant));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_busy       <= 1'b0;
      r_cs         <= 1'b0;
      r_we         <= 1'b0;
      r_drive      <= 1'b0;
      r_rdata      <= 4'd0;
      r_wdata      <= 4'd0;
      r_addr       <= 12'd0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_state      <= ACCESS;
          r_grant      <= w_pick1;
          r_last_grant <= w_pick1;
          r_cnt        <= 3'(WAIT_STATES);
          r_addr       <= w_pick1 ? bus.addr1 : bus.addr0;
          r_wdata      <= w_pick1 ? bus.wdata1 : bus.wdata0;
          r_we         <= w_pick1 ? bus.we1 : bus.we0;
          r_drive      <= w_pick1 ? bus.we1 : bus.we0;
          r_cs         <= 1'b1;
          r_busy       <= 1'b1;
        end
        ACCESS: if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        else begin
          r_state <= TURN;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_drive <= 1'b0;
          r_ack0  <= ~r_grant;
          r_ack1  <= r_grant;
          if (!r_we) r_rdata <= bus.ram_rdata;
        end
        TURN: begin
          r_state <= IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rdata     = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_cs    = r_cs;
  assign bus.ram_we    = r_we;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_drive = r_drive;
endmodule
